// File: rtl/pps_monitor_if.sv
// Bundles the PPS input and measurement results exchanged between the
// monitor (slave) and the pin/status side that observes it (master).
interface pps_monitor_if #(
  parameter int CNT_W = 28
);
  logic             pps_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             missing;
  logic [7:0]       err_cnt;

  modport master (
    output pps_in,
    input  period_out, period_valid, locked, missing, err_cnt
  );

  modport slave (
    input  pps_in,
    output period_out, period_valid, locked, missing, err_cnt
  );
endinterface

// File: rtl/pps_monitor.sv
// Measures an external 1 Hz PPS against clk: period, lock, missing-pulse and error count.
// Define PPS_GLITCH_FILTER_EN to require 3 consecutive high samples before an edge is accepted.
module pps_monitor #(
  parameter int CLK_HZ = 49152000,
  parameter int TOL    = 4915,
  parameter int CNT_W  = 28,
  parameter int LOCK_N = 3
) (
  input  logic         clk,
  input  logic         reset,
  pps_monitor_if.slave bus
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] PER_LO  = CNT_W'(CLK_HZ - TOL);
  localparam logic [CNT_W-1:0] PER_HI  = CNT_W'(CLK_HZ + TOL);
  localparam logic [CNT_W-1:0] PER_TMO = CNT_W'(CLK_HZ + TOL + 1);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  logic       r_sync1, r_sync2, r_armed, r_edge;
  logic [1:0] r_warm;
`ifdef PPS_GLITCH_FILTER_EN
  logic [1:0] r_hiCnt;
`else
  logic       r_prev;
`endif

  // Reset-cleared synchronizer flops look like a low; only arm edge detection
  // once a genuine low has propagated through the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
      r_edge  <= 1'b0;
`ifdef PPS_GLITCH_FILTER_EN
      r_hiCnt <= 2'd0;
`else
      r_prev  <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.pps_in;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      r_armed <= r_armed | (r_warm[1] & ~r_sync2);
`ifdef PPS_GLITCH_FILTER_EN
      r_hiCnt <= r_sync2 ? ((r_hiCnt == 2'd3) ? 2'd3 : r_hiCnt + 2'd1) : 2'd0;
      r_edge  <= r_armed & r_sync2 & (r_hiCnt == 2'd2);
`else
      r_prev  <= r_sync2;
      r_edge  <= r_armed & r_sync2 & ~r_prev;
`endif
    end
  end

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_count, w_countNext;
  logic [CNT_W-1:0] r_period, w_periodNext;
  logic             r_valid, w_validNext;
  logic             r_locked, w_lockedNext;
  logic             r_missing, w_missingNext;
  logic [GW-1:0]    r_good, w_goodNext, w_goodInc;
  logic [7:0]       r_err, w_errNext, w_errInc;
  logic             w_inTol;

  assign w_inTol   = (r_count >= PER_LO) && (r_count <= PER_HI);
  assign w_goodInc = (r_good == GOOD_MAX) ? r_good : r_good + GW'(1);
  assign w_errInc  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  // An edge in the timeout cycle is handled as a (bad) period, never as a timeout.
  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_periodNext  = r_period;
    w_validNext   = 1'b0;
    w_lockedNext  = r_locked;
    w_missingNext = r_missing;
    w_goodNext    = r_good;
    w_errNext     = r_err;
    case (r_state)
      IDLE: begin
        if (r_edge) begin
          w_stateNext   = MEASURE;
          w_countNext   = CNT_W'(1);
          w_missingNext = 1'b0;
        end
      end
      MEASURE: begin
        if (r_edge) begin
          w_periodNext = r_count;
          w_validNext  = 1'b1;
          w_countNext  = CNT_W'(1);
          if (w_inTol) begin
            w_goodNext   = w_goodInc;
            w_lockedNext = (w_goodInc == GOOD_MAX);
          end else begin
            w_goodNext   = '0;
            w_lockedNext = 1'b0;
            w_errNext    = w_errInc;
          end
        end else if (r_count == PER_TMO) begin
          w_stateNext   = IDLE;
          w_countNext   = '0;
          w_missingNext = 1'b1;
          w_lockedNext  = 1'b0;
          w_goodNext    = '0;
          w_errNext     = w_errInc;
        end else begin
          w_countNext = r_count + CNT_W'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_missing <= 1'b0;
      r_good    <= '0;
      r_err     <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_period  <= w_periodNext;
      r_valid   <= w_validNext;
      r_locked  <= w_lockedNext;
      r_missing <= w_missingNext;
      r_good    <= w_goodNext;
      r_err     <= w_errNext;
    end
  end

  assign bus.period_out   = r_period;
  assign bus.period_valid = r_valid;
  assign bus.locked       = r_locked;
  assign bus.missing      = r_missing;
  assign bus.err_cnt      = r_err;

endmodule

// File: doc/pps_monitor.md
Name: pps_monitor

Overview:
- Receive-side counterpart to the 1 Hz divider: measures an externally supplied 1 Hz pulse (PPS) against the local clk.
- Reports the measured period in clk cycles, tolerance lock status, missing-pulse detection and an error count.
- Sits between the board PPS input pin and BDC status/control logic; the local divider output can be looped back for self-test.

Parameters:
- CLK_HZ, 49152000, nominal clk cycles per PPS period.
- TOL, 4915, allowed deviation in cycles, symmetric (±100 ppm at default).
- CNT_W, 28, period counter width; must hold CLK_HZ+TOL+1.
- LOCK_N, 3, consecutive in-tolerance periods required to assert locked.

Ports:
- clk, input, 1, system clock (49.152 MHz nominal).
- reset, input, 1, asynchronous, active-low reset (asserted when 0).
- pps_in, input, 1, asynchronous PPS pulse; rising edge marks the second.
- period_out, output, CNT_W, last measured period in clk cycles.
- period_valid, output, 1, one-cycle strobe when period_out updates.
- locked, output, 1, level; LOCK_N consecutive good periods seen.
- missing, output, 1, level; no edge within CLK_HZ+TOL+1 cycles.
- err_cnt, output, 8, saturating count of bad periods plus timeouts.

Behaviour:
- Reset (reset=0, async): all outputs 0, counter 0, good count 0, synchronizer flops 0, state IDLE.
- Input path: 2-FF synchronizer, then a registered rising-edge detect.
  - edge strobe fires exactly 3 clk rising edges after the first clk edge that samples pps_in high.
  - pps_in high at reset release with no prior low does not produce an edge.
- Counter: on edge, load 1; otherwise increment while in MEASURE. Never wraps, because timeout fires first.
- State IDLE:
  - edge → MEASURE, counter=1.
  - No period_valid.
  - missing cleared.
- State MEASURE:
  - edge → period_out=counter, period_valid=1 for one cycle, counter=1, stay in MEASURE.
  - Good if CLK_HZ−TOL ≤ period ≤ CLK_HZ+TOL (unsigned compare, CNT_W bits).
    - Good: good count +1, saturating at LOCK_N.
    - locked=1 in the same cycle as the period_valid that brings good count to LOCK_N.
  - Bad: good count=0, locked=0, err_cnt +1 (saturating at 255), all in the period_valid cycle.
  - Timeout: counter reaches CLK_HZ+TOL+1 with no edge that cycle → missing=1, locked=0, good count=0, err_cnt +1, counter=0, → IDLE.
- Simultaneous edge and timeout cycle: edge wins. The edge is processed as a MEASURE edge (period CLK_HZ+TOL+1, therefore bad). No separate timeout is counted.
- Next edge after a timeout: returns to MEASURE and clears missing that cycle. The first period after recovery is measured from that edge.
- Mid-operation reset: immediate return to reset values; no partial period reported.
- period_out holds its value between strobes.

Optional Feature:
- Macro: PPS_GLITCH_FILTER_EN.
- When defined:
  - The synchronized input must be high for 3 consecutive clk samples before an edge is accepted; the filtered level is then used for edge detect.
  - Edge latency becomes 5 cycles from first high sample.
  - High pulses shorter than 3 cycles are ignored entirely and do not reset the counter.
  - Filtered level falls on the first low sample.
- When undefined: no filter; 3-cycle latency as above.

Test Plan:
Bench uses CLK_HZ=100, TOL=2, LOCK_N=3, CNT_W=8.
- Reset: drive reset=0 mid-stream with pps toggling → all outputs 0 immediately; after release, first edge gives no period_valid.
- Nominal lock: edges every 100 cycles (1-cycle high) → period_valid with period_out=100 on 2nd, 3rd and 4th edge. locked=1 at the 4th edge's strobe. err_cnt=0.
- Tolerance bounds:
  - Periods 98 and 102 → good.
  - Period 97 → period_out=97, locked=0, err_cnt=1.
  - Then period 103 → err_cnt=2.
- Timeout: after lock, stop pps → missing=1 and locked=0 at cycle 103 after the last edge, err_cnt +1.
  - Resume edges → missing clears on first edge.
  - period_valid only from the second edge, with value 100.
- Simultaneous: place an edge exactly at counter=103 → period_valid, period_out=103, err_cnt +1 only once, missing stays 0.
- Saturation/filter:
  - Force 300 bad periods → err_cnt stays 255.
  - With PPS_GLITCH_FILTER_EN, 2-cycle glitches between good edges → ignored; periods remain 100 and lock held.
